aes_inv_cipher_iter: RTL and testbench

AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_sbox.sv | 38 +++
 rtl/aes_inv_cipher_iter.sv | 182 ++++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helper.
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned NK = 4;
  localparam int unsigned NB = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_INIT   = 2'd2,
    ST_ROUND  = 2'd3
  } aes_state_e;

  // Rcon[1..10] stored at index 0..9
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // GF(2^8) multiply, polynomial 0x11B
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box (INV=0) or inverse S-box (INV=1), computed from GF inverse + affine map.
module aes_sbox
  import aes_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Forward: affine(inv(a)); inverse: inv(affine^-1(a))
  always_comb begin
    if (INV) begin
      y = gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    end else begin
      y = gf_inv(a);
      y = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    end
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then one round per cycle.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  localparam int unsigned RW = 4;

  aes_state_e    state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [127:0]  st_q, st_d, rk_q, rk_d, dout_q, dout_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [127:0]  sb_in, sb_out, add_rk, rnd_out;
  logic [31:0]   ks_word, ks_rot, sub_word;
  logic [RW-1:0] rcon_idx;
  logic [7:0]    rc;

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant k in {9,11,13,14} using its bits as xtime powers
  function automatic logic [7:0] mul_k(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = mul_k(a0, 4'd14) ^ mul_k(a1, 4'd11) ^ mul_k(a2, 4'd13) ^ mul_k(a3, 4'd9);
      o[119-32*c -: 8] = mul_k(a0, 4'd9)  ^ mul_k(a1, 4'd14) ^ mul_k(a2, 4'd11) ^ mul_k(a3, 4'd13);
      o[111-32*c -: 8] = mul_k(a0, 4'd13) ^ mul_k(a1, 4'd9)  ^ mul_k(a2, 4'd14) ^ mul_k(a3, 4'd11);
      o[103-32*c -: 8] = mul_k(a0, 4'd11) ^ mul_k(a1, 4'd13) ^ mul_k(a2, 4'd9)  ^ mul_k(a3, 4'd14);
    end
    return o;
  endfunction

  // rk_(r-1) -> rk_r; sub = SubWord(RotWord(w3))
  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [31:0] sub,
                                           input logic [7:0] rcv);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub ^ {rcv, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // rk_r -> rk_(r-1); sub = SubWord(RotWord(previous w3 = w3 ^ w2))
  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [31:0] sub,
                                           input logic [7:0] rcv);
    logic [31:0] p0, p1, p2, p3;
    p3 = rk[31:0]  ^ rk[63:32];
    p2 = rk[63:32] ^ rk[95:64];
    p1 = rk[95:64] ^ rk[127:96];
    p0 = rk[127:96] ^ sub ^ {rcv, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // Key-schedule word selection and Rcon lookup shared by forward and inverse steps
  always_comb begin
    ks_word  = (state_q == ST_KEYEXP) ? rk_q[31:0] : (rk_q[31:0] ^ rk_q[63:32]);
    ks_rot   = {ks_word[23:0], ks_word[31:24]};
    rcon_idx = (round_q == '0) ? '0 : RW'(round_q - RW'(1));
    rc       = RCON[rcon_idx];
  end

  for (genvar i = 0; i < 4; i++) begin : g_ks_sbox
    aes_sbox #(.INV(1'b0)) u_sbox (.a(ks_rot[31-8*i -: 8]), .y(sub_word[31-8*i -: 8]));
  end

  assign sb_in = inv_shift_rows(st_q);

  for (genvar i = 0; i < 16; i++) begin : g_dp_sbox
    aes_sbox #(.INV(1'b1)) u_sbox (.a(sb_in[127-8*i -: 8]), .y(sb_out[127-8*i -: 8]));
  end

  // Round datapath: AddRoundKey after InvSubBytes/InvShiftRows, InvMixColumns except last
  always_comb begin
    add_rk  = sb_out ^ rk_q;
    rnd_out = (round_q == '0) ? add_rk : inv_mix_columns(add_rk);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    st_d    = st_q;
    rk_d    = rk_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rk_d    = key_in;
          st_d    = data_in;
          round_d = RW'(1);
          state_d = ST_KEYEXP;
        end
      end
      ST_KEYEXP: begin
        rk_d = key_fwd(rk_q, sub_word, rc);
        if (round_q == RW'(NR)) state_d = ST_INIT;
        else                    round_d = RW'(round_q + RW'(1));
      end
      ST_INIT: begin
        st_d    = st_q ^ rk_q;
        rk_d    = key_inv(rk_q, sub_word, rc);
        round_d = RW'(NR - 1);
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        st_d = rnd_out;
        if (round_q == '0) begin
          dout_d  = add_rk;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          rk_d    = key_inv(rk_q, sub_word, rc);
          round_d = RW'(round_q - RW'(1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      st_q    <= '0;
      rk_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS vectors, model-generated random blocks, control corner cases.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in, data_in, data_out;
  logic         busy, done;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 clk = ~clk;

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .data_in(data_in), .busy(busy), .done(done), .data_out(data_out)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: forward AES-128 built from first principles
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[a] = s;
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcv, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcv = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rcv, 24'h0};
        rcv = gmul(rcv, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          u[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Start one block from IDLE, scramble inputs while busy, wait for done
  task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                           output logic [127:0] got, output int lat);
    logic [127:0] prev;
    int idle_early, dout_changes;
    prev = data_out;
    key_in = key; data_in = ct; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'(1));
    check("done_low_after_start", 128'(done), 128'(0));
    key_in = rnd128(); data_in = rnd128();
    lat = -1; idle_early = 0; dout_changes = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done) begin lat = e; break; end
      if (!busy) idle_early++;
      if (data_out !== prev) dout_changes++;
    end
    got = data_out;
    check("busy_until_done", 128'(idle_early), 128'(0));
    check("dout_stable_before_done", 128'(dout_changes), 128'(0));
  endtask

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t         vecs [8];
  logic [127:0] got, k, p;
  int           lat, ndone, first_lat;
  int           done_edges [$];
  logic [127:0] done_data [$];

  initial begin
    rst_n = 1'b0; start = 1'b0; key_in = '0; data_in = '0;
    build_sbox();

    // Reset values
    #1;
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_data_out", data_out, 128'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 128'(busy), 128'(0));

    // Vector table: FIPS pair, boundary keys, random blocks
    vecs[0] = '{C1_KEY, C1_CT, C1_PT};
    vecs[1] = '{B_KEY, B_CT, B_PT};
    vecs[2] = '{128'h0, model_encrypt(128'h0, 128'h0), 128'h0};
    vecs[3] = '{'1, model_encrypt('1, '1), '1};
    for (int i = 4; i < 8; i++) begin
      k = rnd128(); p = rnd128();
      vecs[i] = '{k, model_encrypt(k, p), p};
    end
    // Consecutive entries start during the done cycle (back-to-back)
    for (int i = 0; i < 8; i++) begin
      run_block(vecs[i].key, vecs[i].ct, got, lat);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(21));
      check($sformatf("vec%0d_plaintext", i), got, vecs[i].pt);
    end
    @(posedge clk); #1;
    check("done_one_cycle", 128'(done), 128'(0));
    check("idle_after_done", 128'(busy), 128'(0));

    // Round key 10 probe on the B key, then finish the block
    key_in = B_KEY; data_in = B_CT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("rk10_probe", dut.rk_q, B_RK10);
    lat = -1;
    for (int e = 11; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done) begin lat = e; break; end
    end
    check("probe_latency", 128'(lat), 128'(21));
    check("probe_plaintext", data_out, B_PT);

    // Start pulsed with B at cycle 5 and key change at cycle 8 must be ignored
    @(posedge clk); #1;
    key_in = C1_KEY; data_in = C1_CT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first_lat = -1; got = '0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first_lat < 0) begin first_lat = e; got = data_out; end
      end
      if (e == 4) begin start = 1'b1; key_in = B_KEY; data_in = B_CT; end
      if (e == 5) start = 1'b0;
      if (e == 7) key_in = rnd128();
    end
    check("busy_start_ndone", 128'(ndone), 128'(1));
    check("busy_start_latency", 128'(first_lat), 128'(21));
    check("busy_start_plaintext", got, C1_PT);

    // Reset at cycle 12 abandons the block; restart with B
    key_in = C1_KEY; data_in = C1_CT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", data_out, 128'h0);
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    repeat (2) begin @(posedge clk); #1; if (done) ndone++; end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (done) ndone++; end
    check("midrst_no_done", 128'(ndone), 128'(0));
    run_block(B_KEY, B_CT, got, lat);
    check("postrst_latency", 128'(lat), 128'(21));
    check("postrst_plaintext", got, B_PT);

    // start held high: C.1 then B, one block per 22 cycles
    @(posedge clk); #1;
    key_in = C1_KEY; data_in = C1_CT; start = 1'b1;
    @(posedge clk); #1;
    key_in = B_KEY; data_in = B_CT;
    for (int e = 1; e <= 43; e++) begin
      @(posedge clk); #1;
      if (done) begin done_edges.push_back(e); done_data.push_back(data_out); end
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("held_done_falls", 128'(done), 128'(0));
    check("held_ndone", 128'(done_edges.size()), 128'(2));
    if (done_edges.size() == 2) begin
      check("held_first_edge", 128'(done_edges[0]), 128'(21));
      check("held_second_edge", 128'(done_edges[1]), 128'(43));
      check("held_first_pt", done_data[0], C1_PT);
      check("held_second_pt", done_data[1], B_PT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
